cau_scheduler: RTL and testbench
================================

Name: cau_scheduler

Overview:
- Round-robin job scheduler in front of the convolution accelerator unit's opcode controller.
- Accepts convolution jobs from NUM_REQ requesters, each supplying a 72-bit kernel word and a 72-bit data word.
- Grants one requester at a time and drives the controller's select/opcode/bus command sequence: load kernel (01), load data (10), then run (00) for RUN_CYCLES.
- Pulses a per-requester done on completion; can skip the kernel load when the same requester reuses its already-loaded kernel.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- BUS_W, 72, command bus width (nine 8-bit taps).
- RUN_CYCLES, 11, cycles opcode 00 is held per job (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- req  in  NUM_REQ  per-requester job request, level.
- reuse  in  NUM_REQ  per-requester "kernel unchanged" hint, sampled with req.
- kernel_in  in  NUM_REQ*BUS_W  requester i kernel at [i*BUS_W +: BUS_W].
- data_in  in  NUM_REQ*BUS_W  requester i data at [i*BUS_W +: BUS_W].
- abort  in  1  synchronous job abort.
- grant  out  NUM_REQ  one-hot owner of the accelerator.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- busy  out  1  high in any state other than IDLE.
- select  out  1  accelerator select.
- opcode  out  2  accelerator opcode: 01 load kernel, 10 load data, 00 run.
- bus  out  BUS_W  accelerator command bus.

Behaviour:
- Reset (rst=0, async): state=IDLE; grant, done, busy, select=0; opcode=00; bus=0; rr_ptr=0; kernel_valid=0; run counter=0.
- All state, grant and done are registered. bus is a combinational mux of the granted requester's kernel/data slice, selected by state. Requester holds its inputs stable while granted.
- State machine:
  - IDLE: select=0, opcode=00, bus=0. If any req: pick the first asserted index searching from rr_ptr upward with wrap; latch idx; set grant[idx]=1. Next state is LOAD_D if reuse[idx] & kernel_valid & kern_owner==idx, else LOAD_K.
  - LOAD_K (1 cycle): select=1, opcode=01, bus=kernel slice[idx]. Set kernel_valid=1, kern_owner=idx. Next: LOAD_D.
  - LOAD_D (1 cycle): select=1, opcode=10, bus=data slice[idx]. Clear counter. Next: RUN.
  - RUN: select=1, opcode=00, bus=0. Counter increments each cycle; after exactly RUN_CYCLES cycles, next: DONE.
  - DONE (1 cycle): select=0, done[idx]=1, grant=0, rr_ptr=(idx+1) mod NUM_REQ. Next: IDLE.
- Latency: req sampled at edge E0 → done high in cycle E(3+RUN_CYCLES)..E(4+RUN_CYCLES). On the reuse path, one cycle earlier.
- Back-to-back: minimum one IDLE cycle between jobs. A req still high after done counts as a new job; rr_ptr gives other requesters priority.
- req dropping mid-job: ignored; the job completes and done still pulses.
- abort in LOAD_K/LOAD_D/RUN/DONE: next cycle IDLE; grant=0, select=0, kernel_valid=0, no done pulse; rr_ptr advances past idx. abort in IDLE has no effect and blocks a grant that cycle.
- Simultaneous req from all requesters after reset: grant order 0,1,...,NUM_REQ-1.
- rst asserted mid-job: immediate return to reset values; no done pulse.

Test Plan:
- Single job: reset, req[0]=1, kernel0=72'h010203040506070809, data0=72'h112233445566778899 → grant=01. Next cycles: opcode 01/bus kernel0, then 10/data0, then 00 for 11 cycles, then done[0] for 1 cycle; busy low afterwards.
- Contention: req=2'b11 from reset → requester 0 served first, then requester 1 after one IDLE cycle; grant never has 2 bits set. With req held 2'b11, grants alternate 0,1,0,1.
- Kernel reuse: requester 1 job, then requester 1 again with reuse[1]=1 → second job has no opcode 01 cycle; done arrives one cycle earlier (13 vs 14 cycles). Reuse after requester 0 ran a job → opcode 01 is issued.
- Abort: abort=1 in the 5th RUN cycle → next cycle select=0, grant=0, no done. A following reuse=1 job still issues opcode 01.
- Async reset mid-RUN: rst=0 between clock edges → outputs return to reset values immediately. After release, req[1]-only is granted (rr_ptr=0 search wraps to 1).
- Requester drop: req[0] deasserted during LOAD_D → job completes, done[0] pulses on schedule.

Source files
------------

// File: rtl/cau_scheduler.sv
// Round-robin job scheduler for the convolution accelerator unit.
// Grants one requester at a time and sequences the controller through
// load-kernel, load-data and run, skipping the kernel load when the same
// requester asks to reuse the kernel that is already resident.
module cau_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int BUS_W      = 72,
  parameter int RUN_CYCLES = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       reuse,
  input  logic [NUM_REQ*BUS_W-1:0] kernel_in,
  input  logic [NUM_REQ*BUS_W-1:0] data_in,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     select,
  output logic [1:0]               opcode,
  output logic [BUS_W-1:0]         bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(RUN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_K = 3'd1,
    S_LOAD_D = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   kern_owner;
  logic               kernel_valid;
  logic [CNT_W-1:0]   cnt;

  logic               pick_hit;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               start;
  logic               skip_k;
  logic               run_last;
  logic [IDX_W-1:0]   next_ptr;

  // First asserted request at or above rr_ptr, else the lowest one (wrap)
  always_comb begin
    pick_hit = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_hit && req[i] && (IDX_W'(i) >= rr_ptr)) begin
        pick_hit = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_hit && req[i]) begin
        pick_hit = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end

  // One-hot form of the winning index
  always_comb begin
    pick_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_oh[i] = (pick_idx == IDX_W'(i));
    end
  end

  assign start    = (state == S_IDLE) && pick_hit && !abort;
  assign skip_k   = reuse[pick_idx] && kernel_valid && (kern_owner == pick_idx);
  assign run_last = (cnt == CNT_W'(RUN_CYCLES - 1));
  assign next_ptr = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; abort returns to IDLE from any active state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = skip_k ? S_LOAD_D : S_LOAD_K;
      S_LOAD_K: state_nxt = abort ? S_IDLE : S_LOAD_D;
      S_LOAD_D: state_nxt = abort ? S_IDLE : S_RUN;
      S_RUN:    if (abort) state_nxt = S_IDLE;
                else if (run_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Controller command outputs decoded from the current state
  always_comb begin
    select = 1'b0;
    opcode = 2'b00;
    bus    = '0;
    busy   = (state != S_IDLE);
    case (state)
      S_LOAD_K: begin
        select = 1'b1;
        opcode = 2'b01;
        bus    = kernel_in[int'(idx)*BUS_W +: BUS_W];
      end
      S_LOAD_D: begin
        select = 1'b1;
        opcode = 2'b10;
        bus    = data_in[int'(idx)*BUS_W +: BUS_W];
      end
      S_RUN:   select = 1'b1;
      default: ;
    endcase
  end

  // Grant, completion pulse, arbitration pointer, kernel tracking, run count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant        <= '0;
      done         <= '0;
      rr_ptr       <= '0;
      kernel_valid <= 1'b0;
      cnt          <= '0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: if (start) grant <= pick_oh;
        S_LOAD_K, S_LOAD_D, S_RUN: begin
          if (abort) begin
            grant        <= '0;
            kernel_valid <= 1'b0;
            rr_ptr       <= next_ptr;
          end else if (state == S_LOAD_K) begin
            kernel_valid <= 1'b1;
          end else if (state == S_LOAD_D) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          grant  <= '0;
          rr_ptr <= next_ptr;
          if (abort) kernel_valid <= 1'b0;
          else       done         <= grant;
        end
        default: ;
      endcase
    end
  end

  // Job owner and resident-kernel owner; only meaningful while qualified
  always_ff @(posedge clk) begin
    if (start)                          idx        <= pick_idx;
    if ((state == S_LOAD_K) && !abort)  kern_owner <= idx;
  end

endmodule

// File: tb/tb_cau_scheduler.sv
// Bench for cau_scheduler: directed vector table, hand-written corner
// sequences, and randomized traffic against a job-schedule queue model.
module tb_cau_scheduler;

  localparam int N  = 2;
  localparam int BW = 72;
  localparam int R  = 11;
  localparam int PK = 1, PD = 2, PR = 3, PF = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    reuse = '0;
  logic [N*BW-1:0] kernel_in = '0;
  logic [N*BW-1:0] data_in = '0;
  logic            abort = 1'b0;
  logic [N-1:0]    grant, done;
  logic            busy, select;
  logic [1:0]      opcode;
  logic [BW-1:0]   bus;

  int checks = 0;
  int errors = 0;

  cau_scheduler #(.NUM_REQ(N), .BUS_W(BW), .RUN_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .req(req), .reuse(reuse),
    .kernel_in(kernel_in), .data_in(data_in), .abort(abort),
    .grant(grant), .done(done), .busy(busy), .select(select),
    .opcode(opcode), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; reuse = '0; abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Run one job for requester r; req held two cycles then dropped.
  // lat = edges from request sample to done (-1 if no done seen).
  task automatic run_job(input int r, input bit ru, input bit do_abort,
                         output int lat, output bit saw_k);
    logic [N-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    lat = -1;
    saw_k = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      req   = (c < 2) ? oh : '0;
      reuse = ru ? oh : '0;
      abort = do_abort && (c == 7);
      #1;
      if (c == 1) chk("job_grant", grant, oh);
      if (opcode == 2'b01) saw_k = 1'b1;
      if (do_abort && c == 8) begin
        chk("abort_select", select, 0);
        chk("abort_grant", grant, 0);
        chk("abort_busy", busy, 0);
      end
      if (done[r] && lat < 0) lat = c - 1;
      if (!do_abort && lat >= 0 && c > lat + 2) break;
    end
    abort = 1'b0;
    reuse = '0;
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  reuse;
    logic          abort;
    logic [N-1:0]  grant;
    logic [N-1:0]  done;
    logic          busy;
    logic          sel;
    logic [1:0]    op;
    logic [BW-1:0] bus;
  } vec_t;

  vec_t tv[R+6];

  // Reference model state: pending per-cycle phases of the current job
  int           mq[$];
  int           mown, mrr, mkown;
  bit           mkv;
  logic [N-1:0] mdone;

  task automatic model_reset();
    mq.delete();
    mown = 0; mrr = 0; mkown = 0; mkv = 1'b0; mdone = '0;
  endtask

  task automatic model_check();
    logic [N-1:0]  eg;
    logic          eb, es;
    logic [1:0]    eo;
    logic [BW-1:0] ebus;
    eg = '0; eb = 1'b0; es = 1'b0; eo = 2'b00; ebus = '0;
    if (mq.size() != 0) begin
      eg[mown] = 1'b1;
      eb = 1'b1;
      case (mq[0])
        PK: begin es = 1'b1; eo = 2'b01; ebus = kernel_in[mown*BW +: BW]; end
        PD: begin es = 1'b1; eo = 2'b10; ebus = data_in[mown*BW +: BW]; end
        PR: es = 1'b1;
        default: ;
      endcase
    end
    chk("rnd_grant", grant, eg);
    chk("rnd_done", done, mdone);
    chk("rnd_busy", busy, eb);
    chk("rnd_select", select, es);
    chk("rnd_opcode", opcode, eo);
    chk("rnd_bus", bus, ebus);
  endtask

  task automatic model_step();
    logic [N-1:0] nd;
    int ph;
    bit found;
    nd = '0;
    if (mq.size() == 0) begin
      if (req != '0 && !abort) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && req[(mrr + k) % N]) begin
            found = 1'b1;
            mown = (mrr + k) % N;
          end
        end
        if (!(reuse[mown] && mkv && mkown == mown)) mq.push_back(PK);
        mq.push_back(PD);
        for (int k = 0; k < R; k++) mq.push_back(PR);
        mq.push_back(PF);
      end
    end else begin
      ph = mq.pop_front();
      if (abort) begin
        mq.delete();
        mkv = 1'b0;
        mrr = (mown + 1) % N;
      end else begin
        if (ph == PK) begin mkv = 1'b1; mkown = mown; end
        if (ph == PF) begin nd[mown] = 1'b1; mrr = (mown + 1) % N; end
      end
    end
    mdone = nd;
  endtask

  initial begin
    int lat;
    bit sk;
    int ord[$];
    logic [N-1:0] prev;
    logic [95:0]  rnd;

    // Reset state
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_select", select, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_bus", bus, 0);
    do_reset();

    // Single job vector table
    kernel_in = {72'h0, 72'h010203040506070809};
    data_in   = {72'h0, 72'h112233445566778899};
    for (int k = 0; k < R + 6; k++) begin
      tv[k].req = '0; tv[k].reuse = '0; tv[k].abort = 1'b0;
      tv[k].grant = '0; tv[k].done = '0; tv[k].busy = 1'b0;
      tv[k].sel = 1'b0; tv[k].op = 2'b00; tv[k].bus = '0;
    end
    tv[0].req = 2'b01;
    tv[1].grant = 2'b01; tv[1].busy = 1'b1; tv[1].sel = 1'b1;
    tv[1].op = 2'b01; tv[1].bus = 72'h010203040506070809;
    tv[2].grant = 2'b01; tv[2].busy = 1'b1; tv[2].sel = 1'b1;
    tv[2].op = 2'b10; tv[2].bus = 72'h112233445566778899;
    for (int k = 3; k < 3 + R; k++) begin
      tv[k].grant = 2'b01; tv[k].busy = 1'b1; tv[k].sel = 1'b1;
    end
    tv[R+3].grant = 2'b01; tv[R+3].busy = 1'b1;
    tv[R+4].done = 2'b01;
    for (int k = 0; k < R + 6; k++) begin
      @(negedge clk);
      req = tv[k].req; reuse = tv[k].reuse; abort = tv[k].abort;
      #1;
      chk("tv_grant", grant, tv[k].grant);
      chk("tv_done", done, tv[k].done);
      chk("tv_busy", busy, tv[k].busy);
      chk("tv_select", select, tv[k].sel);
      chk("tv_opcode", opcode, tv[k].op);
      chk("tv_bus", bus, tv[k].bus);
    end

    // Contention: both requesting from reset, grants alternate
    do_reset();
    prev = '0;
    for (int c = 0; c < 150 && ord.size() < 4; c++) begin
      @(negedge clk);
      req = 2'b11; reuse = '0; abort = 1'b0;
      #1;
      chk("grant_onehot", grant & (grant - 2'd1), 0);
      if (grant != '0 && prev == '0) ord.push_back(grant == 2'b10 ? 1 : 0);
      prev = grant;
    end
    req = '0;
    chk("contend_count", ord.size(), 4);
    for (int i = 0; i < ord.size(); i++) chk("contend_order", ord[i], i % 2);

    // Kernel reuse
    do_reset();
    kernel_in = {72'hAAAA_BBBB_CCCC_DDDD_EE, 72'h010203040506070809};
    data_in   = {72'h1234_5678_9ABC_DEF0_11, 72'h112233445566778899};
    run_job(1, 1'b0, 1'b0, lat, sk);
    chk("reuse_first_lat", lat, R + 3);
    chk("reuse_first_k", sk, 1);
    run_job(1, 1'b1, 1'b0, lat, sk);
    chk("reuse_second_lat", lat, R + 2);
    chk("reuse_second_k", sk, 0);
    run_job(0, 1'b0, 1'b0, lat, sk);
    chk("reuse_other_lat", lat, R + 3);
    run_job(1, 1'b1, 1'b0, lat, sk);
    chk("reuse_after_other_k", sk, 1);
    chk("reuse_after_other_lat", lat, R + 3);

    // Abort in the fifth run cycle, then reuse must reload the kernel
    do_reset();
    run_job(0, 1'b0, 1'b0, lat, sk);
    chk("pre_abort_lat", lat, R + 3);
    run_job(0, 1'b0, 1'b1, lat, sk);
    chk("abort_no_done", lat, -1);
    run_job(0, 1'b1, 1'b0, lat, sk);
    chk("post_abort_k", sk, 1);
    chk("post_abort_lat", lat, R + 3);

    // Asynchronous reset in the middle of a run
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req = (c < 2) ? 2'b01 : 2'b00;
      #1;
    end
    chk("mid_run_select", select, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_select", select, 0);
    chk("arst_busy", busy, 0);
    chk("arst_grant", grant, 0);
    chk("arst_opcode", opcode, 0);
    chk("arst_bus", bus, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    run_job(1, 1'b0, 1'b0, lat, sk);
    chk("arst_req1_lat", lat, R + 3);

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      req   = N'($urandom);
      reuse = N'($urandom);
      abort = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < N; i++) begin
        if (!(mq.size() != 0 && mown == i)) begin
          rnd = {$urandom, $urandom, $urandom};
          kernel_in[i*BW +: BW] = rnd[BW-1:0];
          rnd = {$urandom, $urandom, $urandom};
          data_in[i*BW +: BW] = rnd[BW-1:0];
        end
      end
      #1;
      model_check();
      model_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
